// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the small two's-complement helpers used on operands and results.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  function automatic logic [MD_WIDTH-1:0] neg_w(input logic [MD_WIDTH-1:0] x);
    return '0 - x;
  endfunction

  function automatic logic [2*MD_WIDTH-1:0] neg_dw(input logic [2*MD_WIDTH-1:0] x);
    return '0 - x;
  endfunction

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, which is
  // still the correct unsigned magnitude.
  function automatic logic [MD_WIDTH-1:0] abs_w(input logic [MD_WIDTH-1:0] x);
    return x[MD_WIDTH-1] ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one bit per cycle over WIDTH
// cycles on operand magnitudes, followed by a single sign-fixup cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t               state, state_nx;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r;
  logic                 sign_a, sign_b;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 done_r, dbz_r;

  logic                 op_signed, op_div, signs_differ, div_zero;
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum, div_diff;
  logic [2*WIDTH-1:0]   acc_step, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, rs_orig;

  assign op_signed    = op_r[0];
  assign op_div       = op_r[1];
  assign signs_differ = sign_a ^ sign_b;
  assign div_zero     = (b_r == '0);

  // One iteration: shift-add for multiply, restoring step for divide. The
  // divide trial uses WIDTH+1 bits because the shifted remainder can exceed WIDTH.
  always_comb begin
    mul_addend = acc[0] ? a_r : '0;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    div_diff   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_r};
    if (op_div) begin
      if (div_diff[WIDTH])
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = (op_signed && signs_differ) ? neg_dw(acc) : acc;
    quo_fix  = (op_signed && signs_differ) ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = (op_signed && sign_a) ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    rs_orig  = (op_signed && sign_a) ? neg_w(a_r) : a_r;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            a_r    <= op[0] ? abs_w(rs_val) : rs_val;
            b_r    <= op[0] ? abs_w(rt_val) : rt_val;
            sign_a <= op[0] & rs_val[WIDTH-1];
            sign_b <= op[0] & rt_val[WIDTH-1];
            // Accumulator starts cleared in its upper half; the low half seeds
            // the multiplier bits (multiply) or dividend bits (divide).
            acc    <= op[1] ? {{WIDTH{1'b0}}, (op[0] ? abs_w(rs_val) : rs_val)}
                            : {{WIDTH{1'b0}}, (op[0] ? abs_w(rt_val) : rt_val)};
            cnt    <= '0;
          end else begin
            if (hi_we) hi_r <= rs_val;
            if (lo_we) lo_r <= rs_val;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          done_r <= 1'b1;
          if (!op_div) begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi_r  <= rs_orig;
            lo_r  <= '1;
            dbz_r <= 1'b1;
          end else begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule
